// File: rtl/freq_meter_pkg.sv
// ============================================================================
// Module      : freq_meter_pkg
// Description : Shared state encoding and default sizing for the frequency
//               meter and its helpers.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package freq_meter_pkg;

   // Measurement controller states
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_GATE = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Default result width and gate length (1 s at 50 MHz)
   localparam int DEFAULT_CNT_W       = 16;
   localparam int DEFAULT_GATE_CYCLES = 50_000_000;

   // Gate counter width; a one-cycle gate still needs a 1-bit counter
   function automatic int gate_width(input int cycles);
      return (cycles > 1) ? $clog2(cycles) : 1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/freq_meter_edge_sync.sv
// ============================================================================
// Module      : edge_sync
// Description : Two-flop synchronizer for an asynchronous input followed by a
//               history flop; flags one clk cycle per rising edge.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module edge_sync (
   input  logic clk,
   input  logic rst,
   input  logic sig_in,
   output logic rise
);

   logic sync1;
   logic sync2;
   logic hist;

   // Resynchronize sig_in and keep the previous synchronized sample
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         hist  <= 1'b0;
      end else begin
         sync1 <= sig_in;
         sync2 <= sync1;
         hist  <= sync2;
      end
   end

   // A rise is a synchronized 1 whose previous sample was 0
   assign rise = sync2 & ~hist;

endmodule

`default_nettype wire

// File: rtl/freq_meter.sv
// ============================================================================
// Module      : freq_meter
// Description : Counts rising edges of an asynchronous signal over a fixed
//               gate window of clk cycles and publishes the saturating count.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module freq_meter
   import freq_meter_pkg::*;
#(
   parameter int CNT_W       = DEFAULT_CNT_W,
   parameter int GATE_CYCLES = DEFAULT_GATE_CYCLES
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             sig_in,
   output logic [CNT_W-1:0] freq_out,
   output logic             valid,
   output logic             ovf,
   output logic             busy
);

   localparam int                GATE_W    = gate_width(GATE_CYCLES);
   localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
   localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

   state_t            state;
   logic [GATE_W-1:0] gate_cnt;
   logic [CNT_W-1:0]  edge_cnt;
   logic              sat;
   logic              rise;

   edge_sync u_edge_sync (
      .clk    (clk),
      .rst    (rst),
      .sig_in (sig_in),
      .rise   (rise)
   );

   // Gate controller: window timing, edge counting and result publication
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_IDLE;
         gate_cnt <= '0;
         edge_cnt <= '0;
         sat      <= 1'b0;
         freq_out <= '0;
         ovf      <= 1'b0;
         valid    <= 1'b0;
      end else begin
         valid <= 1'b0;
         case (state)
            ST_IDLE: begin
               gate_cnt <= '0;
               edge_cnt <= '0;
               sat      <= 1'b0;
               if (en) state <= ST_GATE;
            end
            ST_GATE: begin
               if (!en) begin
                  // Abort wins even on the final gate cycle; result untouched
                  state    <= ST_IDLE;
                  gate_cnt <= '0;
                  edge_cnt <= '0;
                  sat      <= 1'b0;
               end else begin
                  gate_cnt <= gate_cnt + 1'b1;
                  if (rise) begin
                     // Saturate rather than wrap; remember that counts were lost
                     if (edge_cnt == CNT_MAX) sat <= 1'b1;
                     else                     edge_cnt <= edge_cnt + 1'b1;
                  end
                  if (gate_cnt == GATE_LAST) state <= ST_DONE;
               end
            end
            ST_DONE: begin
               freq_out <= edge_cnt;
               ovf      <= sat;
               valid    <= 1'b1;
               gate_cnt <= '0;
               edge_cnt <= '0;
               sat      <= 1'b0;
               state    <= en ? ST_GATE : ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Window-open indicator comes straight from the state register
   assign busy = (state == ST_GATE);

endmodule

`default_nettype wire
